// File: rtl/g_matrix_stream_pp_if.sv
// Stream bundle for the G-matrix generator: Hq element input beats and G row output.
// The slave modport is the generator's view; master is the driver/consumer view.
interface g_matrix_stream_pp_if #(
    parameter int N  = 16,
    parameter int NR = 4
);
    localparam int IDX_W = (NR > 1) ? $clog2(NR) : 1;

    logic                    Hq_in_valid;
    logic                    Hq_in_ready;
    logic signed [N-1:0]     Hq_in_r;
    logic signed [N-1:0]     Hq_in_i;

    logic                    G_row_valid;
    logic                    G_row_ready;
    logic [IDX_W-1:0]        G_row_idx;
    logic                    G_last;
    logic                    done;

    logic signed [N-1:0]     Ga1_c0_r, Ga1_c0_i, Ga1_c1_r, Ga1_c1_i;
    logic signed [N-1:0]     Ga2_c0_r, Ga2_c0_i, Ga2_c1_r, Ga2_c1_i;
    logic signed [N-1:0]     Gb1_c0_r, Gb1_c0_i, Gb1_c1_r, Gb1_c1_i;
    logic signed [N-1:0]     Gb2_c0_r, Gb2_c0_i, Gb2_c1_r, Gb2_c1_i;

    modport slave (
        input  Hq_in_valid, Hq_in_r, Hq_in_i, G_row_ready,
        output Hq_in_ready, G_row_valid, G_row_idx, G_last, done,
        output Ga1_c0_r, Ga1_c0_i, Ga1_c1_r, Ga1_c1_i,
        output Ga2_c0_r, Ga2_c0_i, Ga2_c1_r, Ga2_c1_i,
        output Gb1_c0_r, Gb1_c0_i, Gb1_c1_r, Gb1_c1_i,
        output Gb2_c0_r, Gb2_c0_i, Gb2_c1_r, Gb2_c1_i
    );

    modport master (
        output Hq_in_valid, Hq_in_r, Hq_in_i, G_row_ready,
        input  Hq_in_ready, G_row_valid, G_row_idx, G_last, done,
        input  Ga1_c0_r, Ga1_c0_i, Ga1_c1_r, Ga1_c1_i,
        input  Ga2_c0_r, Ga2_c0_i, Ga2_c1_r, Ga2_c1_i,
        input  Gb1_c0_r, Gb1_c0_i, Gb1_c1_r, Gb1_c1_i,
        input  Gb2_c0_r, Gb2_c0_i, Gb2_c1_r, Gb2_c1_i
    );
endinterface

// File: rtl/g_matrix_stream_pp.sv
// Double-buffered G-matrix generator: collects NRx2 complex Hq matrices into two
// ping-pong banks and streams one row of Ga1/Ga2/Gb1/Gb2 per cycle with backpressure.
module g_matrix_stream_pp #(
    parameter int N  = 16,
    parameter int NR = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    g_matrix_stream_pp_if.slave bus
);
    localparam int IDX_W = (NR > 1) ? $clog2(NR) : 1;
    localparam int WC_W  = IDX_W + 1;
    localparam int BEATS = 2 * NR;
    localparam logic signed [N-1:0] S_MIN = {1'b1, {(N-1){1'b0}}};
    localparam logic signed [N-1:0] S_MAX = {1'b0, {(N-1){1'b1}}};

    function automatic logic signed [N-1:0] sat_neg(input logic signed [N-1:0] x);
        return (x == S_MIN) ? S_MAX : -x;
    endfunction

    typedef enum logic {R_IDLE, R_STREAM} rstate_t;

    rstate_t             state, state_nxt;
    logic signed [N-1:0] bank_r [2][BEATS];
    logic signed [N-1:0] bank_i [2][BEATS];
    logic [1:0]          full, full_nxt;
    logic                wr_bank, wr_bank_nxt, rd_bank;
    logic [WC_W-1:0]     wr_cnt;
    logic [IDX_W-1:0]    row_cnt;
    logic                rdy_q;
    logic                accept, wr_last, row_last, out_free, load;

    logic                vld_p1, last_p1, done_p1;
    logic [IDX_W-1:0]    idx_p1;
    logic signed [N-1:0] ga1_p1 [4];
    logic signed [N-1:0] ga2_p1 [4];
    logic signed [N-1:0] gb1_p1 [4];
    logic signed [N-1:0] gb2_p1 [4];
    logic signed [N-1:0] h0_r, h0_i, h1_r, h1_i;

    assign accept   = bus.Hq_in_valid && rdy_q;
    assign wr_last  = (wr_cnt == WC_W'(BEATS - 1));
    assign row_last = (row_cnt == IDX_W'(NR - 1));
    assign out_free = !vld_p1 || bus.G_row_ready;

    // Bank flags: completion sets the write bank, the final row load frees the read bank.
    always_comb begin
        full_nxt = full;
        if (accept && wr_last)
            full_nxt[wr_bank] = 1'b1;
        if (load && row_last)
            full_nxt[rd_bank] = 1'b0;
    end

    assign wr_bank_nxt = wr_bank ^ (accept && wr_last);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            R_IDLE: begin
                if (full[rd_bank]) begin
                    state_nxt = R_STREAM;
                    load      = out_free;
                end
            end
            R_STREAM: begin
                load = out_free;
                if (out_free && row_last)
                    state_nxt = full[~rd_bank] ? R_STREAM : R_IDLE;
            end
            default: state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= R_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
            row_cnt <= '0;
            rdy_q   <= 1'b0;
        end else begin
            full    <= full_nxt;
            wr_bank <= wr_bank_nxt;
            rdy_q   <= !full_nxt[wr_bank_nxt];
            if (accept)
                wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
            if (load) begin
                row_cnt <= row_last ? '0 : row_cnt + 1'b1;
                if (row_last)
                    rd_bank <= ~rd_bank;
            end
        end
    end

    // Stage p0: bank storage and row fetch.
    always_ff @(posedge clk) begin
        if (accept) begin
            bank_r[wr_bank][wr_cnt] <= bus.Hq_in_r;
            bank_i[wr_bank][wr_cnt] <= bus.Hq_in_i;
        end
    end

    always_comb begin
        h0_r = bank_r[rd_bank][{row_cnt, 1'b0}];
        h0_i = bank_i[rd_bank][{row_cnt, 1'b0}];
        h1_r = bank_r[rd_bank][{row_cnt, 1'b1}];
        h1_i = bank_i[rd_bank][{row_cnt, 1'b1}];
    end

    // Stage p1: output row register, held until the downstream handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            idx_p1  <= '0;
            done_p1 <= 1'b0;
        end else begin
            done_p1 <= vld_p1 && bus.G_row_ready && last_p1;
            if (load) begin
                vld_p1  <= 1'b1;
                idx_p1  <= row_cnt;
                last_p1 <= row_last;
            end else if (bus.G_row_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                ga1_p1[k] <= '0;
                ga2_p1[k] <= '0;
                gb1_p1[k] <= '0;
                gb2_p1[k] <= '0;
            end
        end else if (load) begin
            ga1_p1[0] <= h0_r;          ga1_p1[1] <= h0_i;
            ga1_p1[2] <= h1_r;          ga1_p1[3] <= h1_i;
            ga2_p1[0] <= h1_r;          ga2_p1[1] <= h1_i;
            ga2_p1[2] <= sat_neg(h0_r); ga2_p1[3] <= sat_neg(h0_i);
            gb1_p1[0] <= h0_r;          gb1_p1[1] <= h0_i;
            gb1_p1[2] <= sat_neg(h1_r); gb1_p1[3] <= sat_neg(h1_i);
            gb2_p1[0] <= h1_r;          gb2_p1[1] <= h1_i;
            gb2_p1[2] <= h0_r;          gb2_p1[3] <= h0_i;
        end
    end

    assign bus.Hq_in_ready = rdy_q;
    assign bus.G_row_valid = vld_p1;
    assign bus.G_row_idx   = idx_p1;
    assign bus.G_last      = last_p1;
    assign bus.done        = done_p1;

    assign bus.Ga1_c0_r = ga1_p1[0];
    assign bus.Ga1_c0_i = ga1_p1[1];
    assign bus.Ga1_c1_r = ga1_p1[2];
    assign bus.Ga1_c1_i = ga1_p1[3];
    assign bus.Ga2_c0_r = ga2_p1[0];
    assign bus.Ga2_c0_i = ga2_p1[1];
    assign bus.Ga2_c1_r = ga2_p1[2];
    assign bus.Ga2_c1_i = ga2_p1[3];
    assign bus.Gb1_c0_r = gb1_p1[0];
    assign bus.Gb1_c0_i = gb1_p1[1];
    assign bus.Gb1_c1_r = gb1_p1[2];
    assign bus.Gb1_c1_i = gb1_p1[3];
    assign bus.Gb2_c0_r = gb2_p1[0];
    assign bus.Gb2_c0_i = gb2_p1[1];
    assign bus.Gb2_c1_r = gb2_p1[2];
    assign bus.Gb2_c1_i = gb2_p1[3];
endmodule
